// File: rtl/vga_stream_out.sv
// vga_stream_out: programmable VGA raster generator that locks an RGB565
// valid/ready pixel stream to the raster. It recovers from stream underflow
// or misplaced start-of-frame markers by re-hunting for the next frame start.
module vga_stream_out #(
    parameter int HDISP   = 640,
    parameter int VDISP   = 480,
    parameter int HFP     = 16,
    parameter int HPULSE  = 96,
    parameter int HBP     = 48,
    parameter int VFP     = 11,
    parameter int VPULSE  = 2,
    parameter int VBP     = 31,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int PIX_DIV = 1,
    parameter int COLOR_W = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               clr_status,
    input  logic [15:0]        pix_data,
    input  logic               pix_sof,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK,
    output logic               VGA_SYNC,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               frame_start,
    output logic               underflow,
    output logic               misalign,
    output logic               locked
);

    localparam int unsigned HTOT = HDISP + HFP + HPULSE + HBP;
    localparam int unsigned VTOT = VDISP + VFP + VPULSE + VBP;
    localparam int HW = (HTOT > 1) ? $clog2(HTOT) : 1;
    localparam int VW = (VTOT > 1) ? $clog2(VTOT) : 1;
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(HTOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(VTOT - 1);

    // Comparison bounds kept 32 bits wide so a zero back porch cannot overflow them.
    localparam int unsigned H_ACTIVE_END = HDISP;
    localparam int unsigned V_ACTIVE_END = VDISP;
    localparam int unsigned H_SYNC_START = HDISP + HFP;
    localparam int unsigned H_SYNC_END   = HDISP + HFP + HPULSE;
    localparam int unsigned V_SYNC_START = VDISP + VFP;
    localparam int unsigned V_SYNC_END   = VDISP + VFP + VPULSE;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DW-1:0] div;
    logic [HW-1:0] ct_h;
    logic [VW-1:0] ct_v;

    logic tick;
    logic active;
    logic hs_on;
    logic vs_on;
    logic at_origin;

    logic ready;
    logic consume;
    logic set_underflow;
    logic set_misalign;

    logic [COLOR_W-1:0] red_full;
    logic [COLOR_W-1:0] green_full;
    logic [COLOR_W-1:0] blue_full;

    assign tick      = (div == DIV_LAST);
    assign active    = (32'(ct_h) < H_ACTIVE_END) && (32'(ct_v) < V_ACTIVE_END);
    assign hs_on     = (32'(ct_h) >= H_SYNC_START) && (32'(ct_h) < H_SYNC_END);
    assign vs_on     = (32'(ct_v) >= V_SYNC_START) && (32'(ct_v) < V_SYNC_END);
    assign at_origin = (ct_h == '0) && (ct_v == '0);

    // RGB565 fields left-aligned into the DAC width with zero fill below.
    assign red_full   = COLOR_W'(pix_data[15:11]) << (COLOR_W - 5);
    assign green_full = COLOR_W'(pix_data[10:5])  << (COLOR_W - 6);
    assign blue_full  = COLOR_W'(pix_data[4:0])   << (COLOR_W - 5);

    assign pix_ready = ready;
    assign locked    = (state == RUN);
    assign VGA_SYNC  = 1'b0;

    // Pixel clock-enable divider and the horizontal/vertical raster counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div  <= '0;
            ct_h <= '0;
            ct_v <= '0;
        end else if (tick) begin
            div <= '0;
            if (ct_h == H_LAST) begin
                ct_h <= '0;
                if (ct_v == V_LAST) begin
                    ct_v <= '0;
                end else begin
                    ct_v <= ct_v + 1'b1;
                end
            end else begin
                ct_h <= ct_h + 1'b1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    // Stream-lock state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: hunt for a frame start at the raster origin, drop lock on any stream fault.
    always_comb begin
        state_next = state;
        if (!EN) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (tick && at_origin && pix_valid && pix_sof) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (tick && active && (!pix_valid || (pix_sof && !at_origin))) begin
                        state_next = WAIT_SOF;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Handshake and event decode: drain stale pixels while hunting, consume one pixel per active tick when locked.
    always_comb begin
        ready         = 1'b0;
        consume       = 1'b0;
        set_underflow = 1'b0;
        set_misalign  = 1'b0;
        if (EN) begin
            case (state)
                WAIT_SOF: begin
                    if (pix_valid) begin
                        if (!pix_sof) begin
                            ready = 1'b1;
                        end else if (tick && at_origin) begin
                            ready   = 1'b1;
                            consume = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (tick && active) begin
                        if (!pix_valid) begin
                            set_underflow = 1'b1;
                        end else if (pix_sof && !at_origin) begin
                            set_misalign = 1'b1;
                        end else begin
                            ready   = 1'b1;
                            consume = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered video outputs, all updated together on the pixel tick so they stay aligned.
    always_ff @(posedge CLK) begin
        if (RST) begin
            VGA_HS    <= ~HS_POL;
            VGA_VS    <= ~VS_POL;
            VGA_BLANK <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
        end else if (tick) begin
            VGA_HS    <= hs_on ? HS_POL : ~HS_POL;
            VGA_VS    <= vs_on ? VS_POL : ~VS_POL;
            VGA_BLANK <= active;
            if (consume) begin
                VGA_R <= red_full;
                VGA_G <= green_full;
                VGA_B <= blue_full;
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

    // Frame-start pulse for the cycle after the origin tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && at_origin;
        end
    end

    // Sticky fault flags; a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            underflow <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            underflow <= set_underflow || (underflow && !clr_status);
            misalign  <= set_misalign  || (misalign  && !clr_status);
        end
    end

endmodule
